assemble_data_segment: RTL

//   Inverse of the 16-bit segment selector: collects 16-bit msg/key segments

---
 rtl/assemble_data_segment.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/assemble_data_segment.sv
// Rebuilds 64-bit msg/key words from 16-bit segments, with an output holding register.
// Optional SEG_INDEX_CHECK_EN: adds seg_idx and drops any segment whose tag does not match the slot.

module assemble_seg_slot #(
  parameter int SEG_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [SEG_W-1:0] msg_in,
  input  logic [SEG_W-1:0] key_in,
  output logic [SEG_W-1:0] msg_out,
  output logic [SEG_W-1:0] key_out
);
  logic [SEG_W-1:0] msg_q, msg_d, key_q, key_d;

  always_comb begin
    msg_d = msg_q;
    key_d = key_q;
    if (wr_en) begin
      msg_d = msg_in;
      key_d = key_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      msg_q <= '0;
      key_q <= '0;
    end else begin
      msg_q <= msg_d;
      key_q <= key_d;
    end
  end

  assign msg_out = msg_q;
  assign key_out = key_q;
endmodule

module assemble_data_segment #(
  parameter int SEG_W   = 16,
  parameter int NUM_SEG = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       seg_valid,
  output logic                       seg_ready,
  input  logic [SEG_W-1:0]           msg_seg,
  input  logic [SEG_W-1:0]           key_seg,
`ifdef SEG_INDEX_CHECK_EN
  input  logic [$clog2(NUM_SEG)-1:0] seg_idx,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SEG_W*NUM_SEG-1:0]   msg,
  output logic [SEG_W*NUM_SEG-1:0]   key,
  output logic                       err
);
  localparam int WORD_W = SEG_W * NUM_SEG;
  localparam int CNT_W  = $clog2(NUM_SEG);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] msg_q, msg_d, key_q, key_d;

  // The last segment goes straight into the output register, so only NUM_SEG-1 slots are stored.
  logic [NUM_SEG-2:0][SEG_W-1:0] slot_msg, slot_key;
  logic [NUM_SEG-2:0]            slot_wr;

  logic last_slot, out_free, accept, idx_bad, take, load, handoff;

  assign last_slot = (cnt_q == CNT_W'(NUM_SEG - 1));
  assign out_free  = !out_valid_q | out_ready;
  assign seg_ready = !(last_slot & !out_free);
  assign accept    = seg_valid & seg_ready;
  assign handoff   = out_valid_q & out_ready;

`ifdef SEG_INDEX_CHECK_EN
  logic err_q, err_d;
  assign idx_bad = (seg_idx != cnt_q);
  assign err_d   = accept & idx_bad;

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign err = err_q;
`else
  assign idx_bad = 1'b0;
  assign err     = 1'b0;
`endif

  assign take = accept & !idx_bad;
  assign load = take & last_slot;

  for (genvar i = 0; i < NUM_SEG - 1; i++) begin : g_slot
    assign slot_wr[i] = take & (cnt_q == CNT_W'(i));
    assemble_seg_slot #(.SEG_W(SEG_W)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (slot_wr[i]),
      .msg_in  (msg_seg),
      .key_in  (key_seg),
      .msg_out (slot_msg[i]),
      .key_out (slot_key[i])
    );
  end

  always_comb begin
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    msg_d       = msg_q;
    key_d       = key_q;
    // A mismatched tag consumes the segment and restarts assembly at slot 0.
    if (accept) cnt_d = idx_bad ? '0 : cnt_q + CNT_W'(1);
    if (handoff) out_valid_d = 1'b0;
    if (load) begin
      out_valid_d = 1'b1;
      msg_d       = {msg_seg, slot_msg};
      key_d       = {key_seg, slot_key};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      msg_q       <= '0;
      key_q       <= '0;
    end else begin
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      msg_q       <= msg_d;
      key_q       <= key_d;
    end
  end

  assign out_valid = out_valid_q;
  assign msg       = msg_q;
  assign key       = key_q;
endmodule
